// File: rtl/rggen_bit_field_w01c_event_pkg.sv
// Shared helpers for rggen event/trigger bit fields.
// get_mask() turns one bit of a register write into a clear/trigger strobe.
package rggen_bit_field_w01c_event_pkg;

    function automatic logic get_mask(
        input logic clear_value,
        input logic mask,
        input logic data
    );
        return mask & (clear_value ? data : ~data);
    endfunction

endpackage

// File: rtl/rggen_bit_field_if.sv
// Register-block to bit-field access interface.
interface rggen_bit_field_if #(
    parameter int WIDTH = 1
);
    logic             valid;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport master (
        output valid, write_mask, write_data,
        input  read_data, value
    );

    modport bit_field (
        input  valid, write_mask, write_data,
        output read_data, value
    );
endinterface

// File: rtl/rggen_edge_detector.sv
// Per-bit rising-edge detector; the history flop resets to 0 so a level
// already high at reset release yields one pulse on the first clock.
module rggen_edge_detector #(
    parameter int WIDTH = 1
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_rise
);
    logic [WIDTH-1:0] set_d;
    logic [WIDTH-1:0] set_q;

    always_comb begin
        set_d = i_in;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            set_q <= '0;
        end else begin
            set_q <= set_d;
        end
    end

    assign o_rise = i_in & ~set_q;
endmodule

// File: rtl/rggen_bit_field_w01c_event.sv
// Sticky event status field with write-0/1-to-clear and registered interrupt.
// Optional RGGEN_BIT_FIELD_EVENT_OVERRUN_EN adds o_overrun (event on a set bit).
module rggen_bit_field_w01c_event
    import rggen_bit_field_w01c_event_pkg::*;
#(
    parameter bit CLEAR_VALUE = 1'b1,
    parameter int WIDTH       = 1,
    parameter bit EDGE_DETECT = 1'b0
)(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    rggen_bit_field_if.bit_field bit_field_if,
    input  logic [WIDTH-1:0]     i_set,
    input  logic [WIDTH-1:0]     i_irq_enable,
    output logic [WIDTH-1:0]     o_status,
    output logic                 o_irq
`ifdef RGGEN_BIT_FIELD_EVENT_OVERRUN_EN
    ,
    output logic [WIDTH-1:0]     o_overrun
`endif
);
    logic [WIDTH-1:0] set_event;
    logic [WIDTH-1:0] clear;
    logic [WIDTH-1:0] status_d;
    logic [WIDTH-1:0] status_q;
    logic             irq_d;
    logic             irq_q;

    if (EDGE_DETECT) begin : g_edge
        rggen_edge_detector #(
            .WIDTH (WIDTH)
        ) u_edge_detector (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_in    (i_set),
            .o_rise  (set_event)
        );
    end else begin : g_level
        assign set_event = i_set;
    end

    // Set has priority over a coincident clear on the same bit.
    always_comb begin
        clear = '0;
        for (int i = 0; i < WIDTH; i++) begin
            clear[i] = bit_field_if.valid &
                       get_mask(CLEAR_VALUE, bit_field_if.write_mask[i], bit_field_if.write_data[i]);
        end
        status_d = (status_q & ~clear) | set_event;
        irq_d    = |(status_q & i_irq_enable);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

`ifdef RGGEN_BIT_FIELD_EVENT_OVERRUN_EN
    logic [WIDTH-1:0] overrun_d;
    logic [WIDTH-1:0] overrun_q;

    // A clear in the same cycle suppresses recording a new overrun.
    always_comb begin
        overrun_d = (overrun_q & ~clear) | (set_event & status_q & ~clear);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign o_overrun = overrun_q;
`endif

    assign bit_field_if.read_data = status_q;
    assign bit_field_if.value     = status_q;
    assign o_status               = status_q;
    assign o_irq                  = irq_q;
endmodule

// File: tb/tb_rggen_bit_field_w01c_event.sv
// Bench for rggen_bit_field_w01c_event: three configurations (W1C level,
// W0C level, W1C edge) driven in lockstep and compared to a per-bit model.
module tb_rggen_bit_field_w01c_event;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] set, mask, data, en;
    logic       valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rggen_bit_field_if #(.WIDTH(4)) if_a ();
    rggen_bit_field_if #(.WIDTH(4)) if_b ();
    rggen_bit_field_if #(.WIDTH(4)) if_c ();

    assign if_a.valid = valid; assign if_a.write_mask = mask; assign if_a.write_data = data;
    assign if_b.valid = valid; assign if_b.write_mask = mask; assign if_b.write_data = data;
    assign if_c.valid = valid; assign if_c.write_mask = mask; assign if_c.write_data = data;

    logic [3:0] st_a, st_b, st_c;
    logic       irq_a, irq_b, irq_c;
`ifdef RGGEN_BIT_FIELD_EVENT_OVERRUN_EN
    logic [3:0] ov_a, ov_b, ov_c;
`endif

    rggen_bit_field_w01c_event #(.CLEAR_VALUE(1'b1), .WIDTH(4), .EDGE_DETECT(1'b0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_a), .i_set(set),
        .i_irq_enable(en), .o_status(st_a), .o_irq(irq_a)
`ifdef RGGEN_BIT_FIELD_EVENT_OVERRUN_EN
        , .o_overrun(ov_a)
`endif
    );
    rggen_bit_field_w01c_event #(.CLEAR_VALUE(1'b0), .WIDTH(4), .EDGE_DETECT(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_b), .i_set(set),
        .i_irq_enable(en), .o_status(st_b), .o_irq(irq_b)
`ifdef RGGEN_BIT_FIELD_EVENT_OVERRUN_EN
        , .o_overrun(ov_b)
`endif
    );
    rggen_bit_field_w01c_event #(.CLEAR_VALUE(1'b1), .WIDTH(4), .EDGE_DETECT(1'b1)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_c), .i_set(set),
        .i_irq_enable(en), .o_status(st_c), .o_irq(irq_c)
`ifdef RGGEN_BIT_FIELD_EVENT_OVERRUN_EN
        , .o_overrun(ov_c)
`endif
    );

    // Gathered DUT outputs, indexed by configuration
    logic [3:0] d_st [3];
    logic [3:0] d_rd [3];
    logic [3:0] d_vl [3];
    logic       d_irq[3];
    logic [3:0] d_ov [3];
    always_comb begin
        d_st[0] = st_a;  d_st[1] = st_b;  d_st[2] = st_c;
        d_rd[0] = if_a.read_data; d_rd[1] = if_b.read_data; d_rd[2] = if_c.read_data;
        d_vl[0] = if_a.value;     d_vl[1] = if_b.value;     d_vl[2] = if_c.value;
        d_irq[0] = irq_a; d_irq[1] = irq_b; d_irq[2] = irq_c;
`ifdef RGGEN_BIT_FIELD_EVENT_OVERRUN_EN
        d_ov[0] = ov_a; d_ov[1] = ov_b; d_ov[2] = ov_c;
`else
        d_ov[0] = '0; d_ov[1] = '0; d_ov[2] = '0;
`endif
    end

    // Reference model state
    bit [3:0] m_status[3];
    bit [3:0] m_prev  [3];
    bit [3:0] m_ovr   [3];
    bit       m_irq   [3];

    function automatic bit cfg_cv(input int k);
        return (k != 1);
    endfunction

    function automatic bit cfg_ed(input int k);
        return (k == 2);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_status[k] = '0; m_prev[k] = '0; m_ovr[k] = '0; m_irq[k] = 1'b0;
        end
    endtask

    task automatic model_tick(input bit [3:0] s, input bit v, input bit [3:0] m,
                              input bit [3:0] d, input bit [3:0] e);
        for (int k = 0; k < 3; k++) begin
            bit any_irq;
            any_irq = 1'b0;
            for (int i = 0; i < 4; i++) begin
                bit ev, clr;
                if (m_status[k][i] && e[i]) any_irq = 1'b1;
                ev  = cfg_ed(k) ? (s[i] && !m_prev[k][i]) : s[i];
                clr = v && m[i] && (d[i] == cfg_cv(k));
                if (ev && m_status[k][i] && !clr) m_ovr[k][i] = 1'b1;
                else if (clr)                     m_ovr[k][i] = 1'b0;
                if (ev)       m_status[k][i] = 1'b1;
                else if (clr) m_status[k][i] = 1'b0;
            end
            m_irq[k]  = any_irq;
            m_prev[k] = s;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d_status", k),    32'(d_st[k]),  32'(m_status[k]));
            check($sformatf("dut%0d_read_data", k), 32'(d_rd[k]),  32'(m_status[k]));
            check($sformatf("dut%0d_value", k),     32'(d_vl[k]),  32'(m_status[k]));
            check($sformatf("dut%0d_irq", k),       32'(d_irq[k]), 32'(m_irq[k]));
`ifdef RGGEN_BIT_FIELD_EVENT_OVERRUN_EN
            check($sformatf("dut%0d_overrun", k),   32'(d_ov[k]),  32'(m_ovr[k]));
`endif
        end
    endtask

    // Called on a falling edge: drive, clock, then compare on the next falling edge.
    task automatic step(input logic [3:0] s, input logic v, input logic [3:0] m,
                        input logic [3:0] d, input logic [3:0] e);
        set = s; valid = v; mask = m; data = d; en = e;
        @(posedge clk);
        model_tick(s, v, m, d, e);
        @(negedge clk);
        compare_all();
    endtask

    // Async reset: outputs must drop without waiting for a clock edge.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_async_status%0d", k), 32'(d_st[k]),  32'd0);
            check($sformatf("rst_async_irq%0d", k),    32'(d_irq[k]), 32'd0);
            check($sformatf("rst_async_ovr%0d", k),    32'(d_ov[k]),  32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] set;
        logic       valid;
        logic [3:0] mask;
        logic [3:0] data;
        logic [3:0] en;
        logic [3:0] exp_st;
        logic       exp_irq;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Expectations for the W1C level-sensitive field (dut_a)
        tbl[0] = '{4'b0101, 1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b0101, 1'b0};
        tbl[1] = '{4'b0000, 1'b1, 4'b1111, 4'b0001, 4'b1000, 4'b0100, 1'b0};
        tbl[2] = '{4'b0010, 1'b1, 4'b1111, 4'b0010, 4'b1000, 4'b0110, 1'b0};
        tbl[3] = '{4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b1110, 1'b0};
        tbl[4] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b1110, 1'b1};
        tbl[5] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1110, 1'b0};
        tbl[6] = '{4'b0000, 1'b1, 4'b1111, 4'b1111, 4'b1000, 4'b0000, 1'b1};
        tbl[7] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 1'b0};
        tbl[8] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 1'b0};
        tbl[9] = '{4'b0000, 1'b1, 4'b0000, 4'b1111, 4'b1000, 4'b0001, 1'b0};

        rst_n = 1'b0;
        set = '0; valid = 1'b0; mask = '0; data = '0; en = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].set, tbl[i].valid, tbl[i].mask, tbl[i].data, tbl[i].en);
            check($sformatf("tbl%0d_status", i), 32'(st_a),  32'(tbl[i].exp_st));
            check($sformatf("tbl%0d_irq", i),    32'(irq_a), 32'(tbl[i].exp_irq));
        end

        // Write-0-clear with a partial mask, then an all-zero mask
        step(4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        check("w0c_preset", 32'(st_b), 32'h0000000f);
        step(4'b0000, 1'b1, 4'b0011, 4'b1010, 4'b0000);
        check("w0c_partial", 32'(st_b), 32'h0000000e);
        step(4'b0000, 1'b1, 4'b0000, 4'b1111, 4'b0000);
        check("w0c_zero_mask", 32'(st_b), 32'h0000000e);

        // Second event on an already-set bit 2
        step(4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        check("sticky_bit2", 32'(st_a[2]), 32'd1);
`ifdef RGGEN_BIT_FIELD_EVENT_OVERRUN_EN
        check("overrun_bit2", 32'(ov_a[2]), 32'd1);
`endif

        // Reset mid-operation with i_set[0] held high across release
        set = 4'b0001; valid = 1'b0;
        pulse_reset();
        step(4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        check("edge_first", 32'(st_c[0]), 32'd1);
        step(4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000);
        check("edge_cleared", 32'(st_c[0]), 32'd0);
        step(4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        check("edge_held_no_event", 32'(st_c[0]), 32'd0);
        check("level_held_resets", 32'(st_a[0]), 32'd1);
        step(4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        check("edge_reraise", 32'(st_c[0]), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [3:0] rs, rm, rd, re;
            logic       rv;
            rs = 4'($urandom & $urandom);
            rv = ($urandom_range(0, 2) == 0);
            rm = 4'($urandom);
            rd = 4'($urandom);
            re = 4'($urandom);
            step(rs, rv, rm, rd, re);
            if (n == 200) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
